// File: rtl/motor_pkg.sv
// Shared types and duty constants for the motor command path.
// Switch groups decode to duties through group_duty().
package motor_pkg;

  typedef enum logic [2:0] {
    StStop,
    StRunFwd,
    StRunRev,
    StDecel,
    StDeadtime
  } motor_state_t;

  typedef enum logic [1:0] {
    DirNone,
    DirFwd,
    DirRev
  } dir_t;

  localparam int unsigned Duty25  = 25;
  localparam int unsigned Duty50  = 50;
  localparam int unsigned Duty75  = 75;
  localparam int unsigned Duty100 = 100;
  localparam int unsigned DutyMax = 100;

  // Highest-index active bit of a 4-bit switch group wins.
  function automatic int unsigned group_duty(input logic [3:0] grp);
    if (grp[3]) return Duty25;
    else if (grp[2]) return Duty50;
    else if (grp[1]) return Duty75;
    else if (grp[0]) return Duty100;
    else return 0;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit switch conditioner: 2-flop synchroniser followed by a stability counter.
// A change is accepted DebounceCycles + 2 cycles after it reaches the pin.
module sw_debounce #(
  parameter int unsigned DebounceCycles = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic sw_o
);

  localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;

  logic            sync1_q, sync2_q, stable_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DebounceCycles - 1)) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign sw_o = stable_q;

endmodule

// File: rtl/motor_cmd_ramp.sv
// Switch-driven duty/direction command generator with soft ramping and
// decel-plus-dead-time sequencing before any bridge reversal.
module motor_cmd_ramp
  import motor_pkg::*;
#(
  parameter int unsigned DebounceCycles = 1_000_000,
  parameter int unsigned RampStepCycles = 100_000,
  parameter int unsigned DeadtimeCycles = 500_000,
  parameter int unsigned DutyW          = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       sw_i,
  output logic [DutyW-1:0] duty_o,
  output logic             in1_o,
  output logic             in2_o,
  output logic             busy_o,
  output logic             conflict_o
);

  localparam int unsigned PrescW = (RampStepCycles > 1) ? $clog2(RampStepCycles) : 1;
  localparam int unsigned DtW    = (DeadtimeCycles > 1) ? $clog2(DeadtimeCycles) : 1;
  // The STOP evaluation cycle also has both pins low, so it completes the dead time.
  localparam int unsigned DtLast = (DeadtimeCycles > 1) ? DeadtimeCycles - 2 : 0;

  logic [7:0] sw_db;

  for (genvar i = 0; i < 8; i++) begin : g_db
    sw_debounce #(
      .DebounceCycles(DebounceCycles)
    ) u_db (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .sw_i (sw_i[i]),
      .sw_o (sw_db[i])
    );
  end

  logic             fwd_any, rev_any;
  dir_t             tgt_dir;
  logic [DutyW-1:0] tgt_duty;

  assign fwd_any    = |sw_db[3:0];
  assign rev_any    = |sw_db[7:4];
  assign conflict_o = fwd_any & rev_any;

  always_comb begin
    tgt_dir  = DirNone;
    tgt_duty = '0;
    if (fwd_any && !rev_any) begin
      tgt_dir  = DirFwd;
      tgt_duty = DutyW'(group_duty(sw_db[3:0]));
    end else if (rev_any && !fwd_any) begin
      tgt_dir  = DirRev;
      tgt_duty = DutyW'(group_duty(sw_db[7:4]));
    end
  end

  logic [PrescW-1:0] presc_q;
  logic              tick;

  assign tick = (presc_q == PrescW'(RampStepCycles - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || tick) presc_q <= '0;
    else               presc_q <= presc_q + PrescW'(1);
  end

  motor_state_t     state_q;
  logic [DutyW-1:0] duty_q;
  logic             in1_q, in2_q, busy_q;
  logic [DtW-1:0]   dt_cnt_q;
  logic             dir_held;

  assign dir_held = (state_q == StRunFwd && tgt_dir == DirFwd) ||
                    (state_q == StRunRev && tgt_dir == DirRev);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StStop;
      duty_q   <= '0;
      in1_q    <= 1'b0;
      in2_q    <= 1'b0;
      busy_q   <= 1'b0;
      dt_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StStop: begin
          if (tgt_dir == DirFwd && tgt_duty != '0) begin
            state_q <= StRunFwd;
            in1_q   <= 1'b1;
          end else if (tgt_dir == DirRev && tgt_duty != '0) begin
            state_q <= StRunRev;
            in2_q   <= 1'b1;
          end
        end
        StRunFwd, StRunRev: begin
          if (dir_held) begin
            if (tick) begin
              if (duty_q < tgt_duty && duty_q < DutyW'(DutyMax)) duty_q <= duty_q + DutyW'(1);
              else if (duty_q > tgt_duty)                        duty_q <= duty_q - DutyW'(1);
            end
          end else begin
            state_q <= StDecel;
            busy_q  <= 1'b1;
          end
        end
        StDecel: begin
          if (duty_q == '0) begin
            state_q  <= StDeadtime;
            in1_q    <= 1'b0;
            in2_q    <= 1'b0;
            dt_cnt_q <= '0;
          end else if (tick) begin
            duty_q <= duty_q - DutyW'(1);
          end
        end
        StDeadtime: begin
          if (dt_cnt_q == DtW'(DtLast)) begin
            state_q <= StStop;
            busy_q  <= 1'b0;
          end else begin
            dt_cnt_q <= dt_cnt_q + DtW'(1);
          end
        end
        default: state_q <= StStop;
      endcase
    end
  end

  assign duty_o = duty_q;
  assign in1_o  = in1_q;
  assign in2_o  = in2_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Directed bench for motor_cmd_ramp with short debounce, ramp and dead-time periods.
module tb_motor_cmd_ramp;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] sw_i;
  logic [6:0] duty_o;
  logic       in1_o, in2_o, busy_o, conflict_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          both_hi_seen = 1'b0;

  motor_cmd_ramp #(
    .DebounceCycles(4),
    .RampStepCycles(2),
    .DeadtimeCycles(8),
    .DutyW         (7)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .sw_i      (sw_i),
    .duty_o    (duty_o),
    .in1_o     (in1_o),
    .in2_o     (in2_o),
    .busy_o    (busy_o),
    .conflict_o(conflict_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (in1_o && in2_o) both_hi_seen = 1'b1;

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_outs(input string tag, input int unsigned duty, input bit in1,
                            input bit in2, input bit busy);
    check_eq({tag, ".duty"}, duty_o, duty);
    check_eq({tag, ".in1"},  in1_o,  in1);
    check_eq({tag, ".in2"},  in2_o,  in2);
    check_eq({tag, ".busy"}, busy_o, busy);
  endtask

  initial begin
    int  busy_hits, low_cnt, low_idle, viol;
    bit  got_rev, found;

    // Reset state and a short glitch that must be rejected
    rst_i = 1'b1;
    sw_i  = 8'h00;
    step(3);
    check_outs("rst0", 0, 0, 0, 0);
    check_eq("rst0.conflict", conflict_o, 0);
    rst_i = 1'b0;
    step(2);
    sw_i = 8'h01;
    step(2);
    sw_i = 8'h00;
    step(20);
    check_outs("glitch", 0, 0, 0, 0);

    // Reset with sw0 held, then exact debounce latency and ramp timing
    sw_i  = 8'h01;
    rst_i = 1'b1;
    step(3);
    check_outs("rst1", 0, 0, 0, 0);
    rst_i = 1'b0;
    step(6);
    check_eq("deb.before.in1", in1_o, 0);
    step(1);
    check_outs("deb.accept", 0, 1, 0, 0);
    step(1);
    check_eq("ramp.first", duty_o, 1);
    step(196);
    check_eq("ramp.99", duty_o, 99);
    step(2);
    check_eq("ramp.100", duty_o, 100);
    step(20);
    check_outs("ramp.hold", 100, 1, 0, 0);

    // Same-direction ramp down to 25, never busy
    sw_i = 8'h08;
    busy_hits = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (busy_o) busy_hits++;
    end
    check_eq("down25.busy_hits", busy_hits, 0);
    check_outs("down25", 25, 1, 0, 0);

    sw_i = 8'h04;
    step(100);
    check_outs("up50", 50, 1, 0, 0);

    // Reversal: decel with in1 held, 8 cycles both low, then reverse ramp
    sw_i = 8'h10;
    low_cnt = 0; low_idle = 0; viol = 0; got_rev = 1'b0;
    for (int i = 0; i < 400 && !got_rev; i++) begin
      step(1);
      if (in2_o) begin
        got_rev = 1'b1;
      end else if (!in1_o) begin
        low_cnt++;
        if (!busy_o) low_idle++;
        if (duty_o != 0) viol++;
      end else if (busy_o && duty_o != 0 && !in1_o) begin
        viol++;
      end
    end
    check_eq("rev.reached", got_rev, 1);
    check_eq("rev.low_cycles", low_cnt, 8);
    check_eq("rev.low_not_busy", low_idle, 1);
    check_eq("rev.viol", viol, 0);
    check_outs("rev.start", 0, 0, 1, 0);
    step(220);
    check_outs("rev.full", 100, 0, 1, 0);

    // Back to forward 75, then both groups active
    sw_i = 8'h02;
    step(450);
    check_outs("fwd75", 75, 1, 0, 0);
    sw_i = 8'h11;
    step(5);
    check_eq("conf.before", conflict_o, 0);
    step(1);
    check_eq("conf.set", conflict_o, 1);
    step(250);
    check_outs("conf.stop", 0, 0, 0, 0);
    check_eq("conf.held", conflict_o, 1);
    step(20);
    check_outs("conf.stay", 0, 0, 0, 0);

    // Reset in the middle of a decel at duty 40
    sw_i = 8'h04;
    step(150);
    check_outs("pre.decel", 50, 1, 0, 0);
    check_eq("pre.decel.conflict", conflict_o, 0);
    sw_i  = 8'h00;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(1);
      if (duty_o == 40 && busy_o) found = 1'b1;
    end
    check_eq("decel40.found", found, 1);
    rst_i = 1'b1;
    step(1);
    check_outs("mid.rst", 0, 0, 0, 0);
    rst_i = 1'b0;
    step(10);
    check_outs("post.rst", 0, 0, 0, 0);

    check_eq("in1_in2_exclusive", both_hi_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
